// File: rtl/fdivsqrt_iter_ctrl.sv
// Sequencing controller for the radix-4 divide/sqrt iteration datapath.
// Issues a one-cycle init pulse, then N iteration enables. It owns the OTFC
// digit-position constant C and presents a Done/Stall handshake downstream.
module fdivsqrt_iter_ctrl #(
  parameter int DIVb = 64,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic            SqrtE,
  input  logic            Special,
  input  logic [CNTW-1:0] CycleCnt,
  input  logic            Flush,
  input  logic            Stall,
  output logic            Busy,
  output logic            InitEn,
  output logic            IterEn,
  output logic [DIVb:0]   C,
  output logic            Done,
  output logic            Bypass
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Divide retires one digit above the binary point, sqrt one more.
  localparam logic [DIVb:0]   C_DIV   = {2'b11,  {(DIVb-1){1'b0}}};
  localparam logic [DIVb:0]   C_SQRT  = {3'b111, {(DIVb-2){1'b0}}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            accept;

  // Start is only honoured in IDLE; reset gates it so outputs stay quiet
  // while reset is held even with Start asserted.
  assign accept = (state == IDLE) & Start & ~Flush & ~reset;
  assign Busy   = (state != IDLE);
  assign InitEn = accept & ~Special;
  assign IterEn = (state == BUSY) & ~Flush;
  assign Done   = (state == DONE) & ~Flush;

  // State, iteration counter, OTFC constant and bypass flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      C      <= '0;
      Bypass <= 1'b0;
    end else if (Flush) begin
      // Abort; C is left as-is, the next accepted op reloads it.
      state  <= IDLE;
      cnt    <= '0;
      Bypass <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && Special) begin
            state  <= DONE;
            Bypass <= 1'b1;
          end else if (accept) begin
            state <= BUSY;
            cnt   <= (CycleCnt == '0) ? CNT_ONE : CycleCnt;
            C     <= SqrtE ? C_SQRT : C_DIV;
          end
        end
        BUSY: begin
          // Shift in ones two at a time; saturates at all ones naturally.
          C   <= {2'b11, C[DIVb:2]};
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= DONE;
        end
        DONE: begin
          if (!Stall) begin
            state  <= IDLE;
            Bypass <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Self-checking bench for fdivsqrt_iter_ctrl: directed scenarios followed by
// randomized traffic, compared against a behavioural model that tracks the
// operation phase, remaining steps and the number of leading ones in C.
module tb_fdivsqrt_iter_ctrl;
  localparam int DIVb = 64;
  localparam int CNTW = 6;

  logic            clk = 1'b0;
  logic            reset, Start, SqrtE, Special, Flush, Stall;
  logic [CNTW-1:0] CycleCnt;
  logic            Busy, InitEn, IterEn, Done, Bypass;
  logic [DIVb:0]   C;

  fdivsqrt_iter_ctrl #(.DIVb(DIVb), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .Start(Start), .SqrtE(SqrtE), .Special(Special),
    .CycleCnt(CycleCnt), .Flush(Flush), .Stall(Stall), .Busy(Busy),
    .InitEn(InitEn), .IterEn(IterEn), .C(C), .Done(Done), .Bypass(Bypass)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Model: phase 0 = waiting, 1 = iterating, 2 = result held.
  int ph = 0;
  int rem = 0;
  int ones = 0;
  bit mbyp = 1'b0;

  function automatic logic [DIVb:0] cval(int k);
    logic [DIVb:0] v;
    v = '0;
    for (int i = 0; i < k && i <= DIVb; i++) v[DIVb-i] = 1'b1;
    return v;
  endfunction

  task automatic chk(string tag, logic [DIVb:0] obs, logic [DIVb:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; rem = 0; ones = 0; mbyp = 1'b0;
  endtask

  // Compare every output against what the model predicts for current inputs.
  task automatic check_all(string tag);
    logic e_busy, e_init, e_iter, e_done, e_byp;
    logic [DIVb:0] e_c;
    if (reset) begin
      e_busy = 0; e_init = 0; e_iter = 0; e_done = 0; e_byp = 0; e_c = '0;
    end else begin
      e_busy = (ph != 0);
      e_init = (ph == 0) && Start && !Flush && !Special;
      e_iter = (ph == 1) && !Flush;
      e_done = (ph == 2) && !Flush;
      e_byp  = mbyp;
      e_c    = cval(ones);
    end
    chk({tag, ".Busy"},   {{DIVb{1'b0}}, Busy},   {{DIVb{1'b0}}, e_busy});
    chk({tag, ".InitEn"}, {{DIVb{1'b0}}, InitEn}, {{DIVb{1'b0}}, e_init});
    chk({tag, ".IterEn"}, {{DIVb{1'b0}}, IterEn}, {{DIVb{1'b0}}, e_iter});
    chk({tag, ".Done"},   {{DIVb{1'b0}}, Done},   {{DIVb{1'b0}}, e_done});
    chk({tag, ".Bypass"}, {{DIVb{1'b0}}, Bypass}, {{DIVb{1'b0}}, e_byp});
    chk({tag, ".C"},      C,                      e_c);
  endtask

  task automatic model_clock();
    if (reset) begin
      model_reset();
    end else if (Flush) begin
      ph = 0; rem = 0; mbyp = 1'b0;
    end else if (ph == 0) begin
      if (Start && Special) begin
        ph = 2; mbyp = 1'b1;
      end else if (Start) begin
        ph = 1;
        rem = (CycleCnt == 0) ? 1 : int'(CycleCnt);
        ones = SqrtE ? 3 : 2;
      end
    end else if (ph == 1) begin
      ones = (ones + 2 > DIVb + 1) ? DIVb + 1 : ones + 2;
      if (rem == 1) ph = 2;
      rem--;
    end else begin
      if (!Stall) begin ph = 0; mbyp = 1'b0; end
    end
  endtask

  // One clock cycle: drive, settle, check, clock edge, advance model.
  task automatic step(string tag, bit st, bit sq, bit sp, int n, bit fl, bit sl);
    Start = st; SqrtE = sq; Special = sp; CycleCnt = CNTW'(n); Flush = fl; Stall = sl;
    #1;
    check_all(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_steps(string tag, int cnt);
    for (int i = 0; i < cnt; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 0; Start = 0; SqrtE = 0; Special = 0; CycleCnt = '0; Flush = 0; Stall = 0;
    #2 reset = 1;

    // Reset held with Start asserted: everything quiet.
    for (int i = 0; i < 3; i++) step("rst", 1, 0, 0, 4, 0, 0);
    reset = 0;
    idle_steps("idle", 2);

    // Divide, N=4.
    step("div4.start", 1, 0, 0, 4, 0, 0);
    idle_steps("div4.run", 6);
    chk("div4.C10", C, cval(10));

    // Sqrt, N=2, stall for 3 cycles in DONE.
    step("sq2.start", 1, 1, 0, 2, 0, 0);
    idle_steps("sq2.run", 2);
    chk("sq2.C7", C, cval(7));
    for (int i = 0; i < 3; i++) step("sq2.stall", 0, 0, 0, 0, 0, 1);
    idle_steps("sq2.rel", 2);

    // Special bypass with Start pulses during DONE.
    step("sp.start", 1, 0, 1, 20, 0, 0);
    step("sp.ign1", 1, 0, 0, 5, 0, 1);
    step("sp.ign2", 1, 0, 0, 5, 0, 1);
    idle_steps("sp.rel", 2);

    // Flush in cycle 2 of a 6-step divide, then a fresh Start.
    step("fl.start", 1, 0, 0, 6, 0, 0);
    step("fl.c1", 0, 0, 0, 0, 0, 0);
    step("fl.flush", 1, 0, 0, 3, 1, 1);
    step("fl.restart", 1, 1, 0, 3, 0, 0);
    idle_steps("fl.run", 5);

    // CycleCnt=0 behaves as a single step.
    step("z.start", 1, 0, 0, 0, 0, 0);
    idle_steps("z.run", 3);

    // CycleCnt=0 again, async reset mid-cycle while BUSY.
    step("zr.start", 1, 0, 0, 0, 0, 0);
    Start = 0; #1;
    check_all("zr.busy");
    #1 reset = 1;
    #1 check_all("zr.async");
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    idle_steps("zr.after", 2);

    // Randomized traffic, including long ops that saturate C.
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(1, 0) == 1),
           ($urandom_range(1, 0) == 1),
           ($urandom_range(7, 0) == 0),
           int'($urandom_range(40, 0)),
           ($urandom_range(15, 0) == 0),
           ($urandom_range(2, 0) == 0));
    end
    idle_steps("drain", 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
